// File: rtl/writeback_unit_if.sv
// ============================================================================
// writeback_unit_if : ALU/load/issue/query/write-port bundle for writeback_unit
// Revision 1.0
// ============================================================================
`default_nettype none

interface writeback_unit_if;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic [4:0]  chk_addr_1;
    logic [4:0]  chk_addr_2;
    logic        stall_1;
    logic        stall_2;
    logic        wb_we;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic [3:0]  fifo_count;

    modport master (
        output alu_valid, alu_reg, alu_data,
        output ld_valid, ld_reg, ld_data,
        output iss_valid, iss_reg,
        output chk_addr_1, chk_addr_2,
        input  ld_ready, stall_1, stall_2,
        input  wb_we, wb_write_reg, wb_write_data, fifo_count
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  ld_valid, ld_reg, ld_data,
        input  iss_valid, iss_reg,
        input  chk_addr_1, chk_addr_2,
        output ld_ready, stall_1, stall_2,
        output wb_we, wb_write_reg, wb_write_data, fifo_count
    );
endinterface

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// writeback_unit : ALU-first register write port, load-result queue, pending
//                  scoreboard. Define WB_LOAD_BYPASS_EN for empty-queue bypass.
// Revision 1.0
// ============================================================================
`default_nettype none

module writeback_unit #(
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    writeback_unit_if.slave bus
);

    localparam int                c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [3:0]        c_DEPTH = 4'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(FIFO_DEPTH - 1);

    logic               r_ready_en;
    logic [3:0]         r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [4:0]         r_mem_reg  [FIFO_DEPTH];
    logic [31:0]        r_mem_data [FIFO_DEPTH];
    logic [31:0]        r_pending;
    logic               r_wb_we;
    logic [4:0]         r_wb_reg;
    logic [31:0]        r_wb_data;

    logic        w_ld_ready;
    logic        w_ld_acc;
    logic        w_ld_nz;
    logic        w_alu_win;
    logic        w_empty;
    logic        w_bypass;
    logic        w_pop;
    logic        w_push;
    logic        w_clr;
    logic        w_wb_we;
    logic [4:0]  w_wb_reg;
    logic [31:0] w_wb_data;
    logic [31:0] w_pending_nxt;

    // rst_n gates ready so a source never sees a handshake that reset discards.
    assign w_ld_ready = rst_n & r_ready_en & (r_count < c_DEPTH);
    assign w_ld_acc   = bus.ld_valid & w_ld_ready;
    assign w_ld_nz    = (bus.ld_reg != 5'd0);
    assign w_alu_win  = bus.alu_valid & (bus.alu_reg != 5'd0);
    assign w_empty    = (r_count == 4'd0);

`ifdef WB_LOAD_BYPASS_EN
    assign w_bypass = w_ld_acc & w_ld_nz & w_empty & ~w_alu_win;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop  = ~w_alu_win & ~w_empty;
    assign w_push = w_ld_acc & w_ld_nz & ~w_bypass;

    always_comb begin
        w_wb_we   = 1'b0;
        w_wb_reg  = r_wb_reg;
        w_wb_data = r_wb_data;
        w_clr     = 1'b0;
        if (w_alu_win) begin
            w_wb_we   = 1'b1;
            w_wb_reg  = bus.alu_reg;
            w_wb_data = bus.alu_data;
        end else if (w_pop) begin
            w_wb_we   = 1'b1;
            w_wb_reg  = r_mem_reg[r_rd_ptr];
            w_wb_data = r_mem_data[r_rd_ptr];
            w_clr     = 1'b1;
        end else if (w_bypass) begin
            w_wb_we   = 1'b1;
            w_wb_reg  = bus.ld_reg;
            w_wb_data = bus.ld_data;
            w_clr     = 1'b1;
        end
    end

    // Clear first, then set, so an issue to the register being written back wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_clr) begin
            w_pending_nxt[w_wb_reg] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_reg != 5'd0)) begin
            w_pending_nxt[bus.iss_reg] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready_en <= 1'b0;
            r_count    <= 4'd0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_pending  <= 32'd0;
            r_wb_we    <= 1'b0;
            r_wb_reg   <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            r_ready_en <= 1'b1;
            r_count    <= r_count + {3'd0, w_push} - {3'd0, w_pop};
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            r_pending  <= w_pending_nxt;
            r_wb_we    <= w_wb_we;
            r_wb_reg   <= w_wb_reg;
            r_wb_data  <= w_wb_data;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem_reg[r_wr_ptr]  <= bus.ld_reg;
            r_mem_data[r_wr_ptr] <= bus.ld_data;
        end
    end

    assign bus.ld_ready      = w_ld_ready;
    assign bus.stall_1       = r_pending[bus.chk_addr_1];
    assign bus.stall_2       = r_pending[bus.chk_addr_2];
    assign bus.wb_we         = r_wb_we;
    assign bus.wb_write_reg  = r_wb_reg;
    assign bus.wb_write_data = r_wb_data;
    assign bus.fifo_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// tb_writeback_unit : queue-based reference model with scoreboard monitor
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    writeback_unit_if bus();

    writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t         m_q[$];
    wr_t         exp_q[$];
    logic [31:0] m_pend = 32'd0;
    bit          m_ready_en = 1'b0;
    logic [4:0]  m_last_reg = 5'd0;
    logic [31:0] m_last_data = 32'd0;
    int          errors = 0;
    int          checks = 0;
    bit          done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: queue semantics taken straight from the write-port rules.
    always @(posedge clk) begin : model
        wr_t w;
        bit  rdy, acc, alu_win, byp, wrote;
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_pend      = 32'd0;
            m_ready_en  = 1'b0;
            m_last_reg  = 5'd0;
            m_last_data = 32'd0;
        end else begin
            rdy     = m_ready_en && (m_q.size() < DEPTH);
            acc     = bus.ld_valid && rdy;
            alu_win = bus.alu_valid && (bus.alu_reg != 5'd0);
            byp     = 1'b0;
            wrote   = 1'b0;
            if (alu_win) begin
                w.r = bus.alu_reg; w.d = bus.alu_data; wrote = 1'b1;
            end else if (m_q.size() > 0) begin
                w = m_q.pop_front(); wrote = 1'b1; m_pend[w.r] = 1'b0;
            end
`ifdef WB_LOAD_BYPASS_EN
            else if (acc && bus.ld_reg != 5'd0) begin
                w.r = bus.ld_reg; w.d = bus.ld_data; wrote = 1'b1; byp = 1'b1;
                m_pend[w.r] = 1'b0;
            end
`endif
            if (wrote) begin
                exp_q.push_back(w);
                m_last_reg  = w.r;
                m_last_data = w.d;
            end
            if (acc && bus.ld_reg != 5'd0 && !byp) begin
                w.r = bus.ld_reg; w.d = bus.ld_data;
                m_q.push_back(w);
            end
            if (bus.iss_valid && bus.iss_reg != 5'd0) m_pend[bus.iss_reg] = 1'b1;
            m_ready_en = 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        wr_t w;
        if (!done) begin
            if (bus.wb_we) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_wb actual=we(r%0d) required=no_write at %0t",
                             bus.wb_write_reg, $time);
                end else begin
                    w = exp_q.pop_front();
                    chk("wb_reg", 32'(bus.wb_write_reg), 32'(w.r));
                    chk("wb_data", bus.wb_write_data, w.d);
                end
            end else begin
                chk("wb_hold_reg", 32'(bus.wb_write_reg), 32'(m_last_reg));
                chk("wb_hold_data", bus.wb_write_data, m_last_data);
            end
            chk("missed_wb", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            chk("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
            chk("ld_ready", 32'(bus.ld_ready),
                32'(rst_n && m_ready_en && (m_q.size() < DEPTH)));
            chk("stall_1", 32'(bus.stall_1), 32'(m_pend[bus.chk_addr_1]));
            chk("stall_2", 32'(bus.stall_2), 32'(m_pend[bus.chk_addr_2]));
        end
    end

    task automatic idle();
        bus.alu_valid  = 1'b0; bus.alu_reg = 5'd0; bus.alu_data = 32'd0;
        bus.ld_valid   = 1'b0; bus.ld_reg  = 5'd0; bus.ld_data  = 32'd0;
        bus.iss_valid  = 1'b0; bus.iss_reg = 5'd0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int k;
        idle();
        bus.chk_addr_1 = 5'd0;
        bus.chk_addr_2 = 5'd0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);

        // ALU r5 and load r6 in the same cycle
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'h1111_1111;
        bus.ld_valid  = 1'b1; bus.ld_reg  = 5'd6; bus.ld_data  = 32'hAAAA_0000;
        step(1);
        idle();
        step(3);

        // ALU held busy while five loads are offered; queue fills then drains in order
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd3;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            bus.alu_data = 32'hC0DE_0000 + 32'(c);
            bus.ld_valid = (k < 5);
            bus.ld_reg   = 5'(10 + k);
            bus.ld_data  = 32'hBEEF_0000 + 32'(k);
            if (bus.ld_ready && k < 5) k++;
            step(1);
        end
        idle();
        step(8);

        // Issue r7, observe stall, then its load clears it
        bus.chk_addr_1 = 5'd7; bus.chk_addr_2 = 5'd6;
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd7;
        step(1);
        idle();
        step(2);
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd7; bus.ld_data = 32'h7777_0001;
        step(1);
        idle();
        step(3);

        // Set and clear of r7 colliding
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd7;
        bus.ld_valid  = 1'b1; bus.ld_reg  = 5'd7; bus.ld_data = 32'h7777_0002;
        step(1);
        bus.ld_valid = 1'b0;
        step(1);
        idle();
        step(2);
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd7; bus.ld_data = 32'h7777_0003;
        step(1);
        idle();
        step(3);

        // r0 targets: nothing written, nothing queued, nothing pending
        bus.chk_addr_1 = 5'd0; bus.chk_addr_2 = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hDEAD_0000;
        bus.ld_valid  = 1'b1; bus.ld_reg  = 5'd0; bus.ld_data  = 32'hDEAD_0001;
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd0;
        step(1);
        idle();
        step(3);

        // Reset taken with three queued loads, then a single idle load to r9
        bus.alu_valid = 1'b1; bus.alu_reg = 5'd4;
        for (int c = 0; c < 3; c++) begin
            bus.alu_data = 32'h4444_0000 + 32'(c);
            bus.ld_valid = 1'b1; bus.ld_reg = 5'(11 + c); bus.ld_data = 32'h5555_0000 + 32'(c);
            bus.iss_valid = 1'b1; bus.iss_reg = 5'(11 + c);
            step(1);
        end
        idle();
        bus.chk_addr_1 = 5'd11; bus.chk_addr_2 = 5'd12;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        bus.ld_valid = 1'b1; bus.ld_reg = 5'd9; bus.ld_data = 32'h9999_9999;
        step(1);
        idle();
        step(3);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            bus.alu_valid  = ($urandom_range(0, 2) == 0);
            bus.alu_reg    = 5'($urandom_range(0, 9));
            bus.alu_data   = $urandom;
            bus.ld_valid   = ($urandom_range(0, 1) == 0);
            bus.ld_reg     = 5'($urandom_range(0, 9));
            bus.ld_data    = $urandom;
            bus.iss_valid  = ($urandom_range(0, 3) == 0);
            bus.iss_reg    = 5'($urandom_range(0, 9));
            bus.chk_addr_1 = 5'($urandom_range(0, 9));
            bus.chk_addr_2 = 5'($urandom_range(0, 31));
            rst_n          = ($urandom_range(0, 99) != 0);
            step(1);
        end
        idle();
        rst_n = 1'b1;
        step(12);

        done = 1'b1;
        chk("final_queue_empty", 32'(m_q.size()), 32'(bus.fifo_count));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, setting the load-result queue depth; legal values are 2, 4 and 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port alu_valid, input, 1 bit: an ALU result is present this cycle; there is no back-pressure.
REQ-005 The block SHALL have ports alu_reg (input, 5 bits) and alu_data (input, 32 bits): the ALU destination register and result.
REQ-006 The block SHALL have ports ld_valid (input, 1 bit), ld_reg (input, 5 bits) and ld_data (input, 32 bits): the load-result source.
REQ-007 The block SHALL have port ld_ready, output, 1 bit: a load result is accepted when ld_valid and ld_ready are both high.
REQ-008 The block SHALL have ports iss_valid (input, 1 bit) and iss_reg (input, 5 bits): a load has been issued and will write iss_reg.
REQ-009 The block SHALL have ports chk_addr_1 and chk_addr_2 (input, 5 bits each) and stall_1 and stall_2 (output, 1 bit each): the pending-write query.
REQ-010 The block SHALL have ports wb_we (output, 1 bit), wb_write_reg (output, 5 bits) and wb_write_data (output, 32 bits): the register-file write port, all registered.
REQ-011 The block SHALL have port fifo_count, output, 4 bits: the current queue occupancy.

Function
REQ-012 The write port SHALL have 1-cycle latency: the values chosen in cycle N appear on wb_* after the rising edge ending cycle N.
REQ-013 Write-port priority SHALL be fixed, with ALU first:
- if alu_valid and alu_reg is not 0, drive alu_reg and alu_data with wb_we=1;
- otherwise, if the queue is not empty, pop the head and drive it with wb_we=1;
- otherwise, drive wb_we=0, and wb_write_reg and wb_write_data SHALL hold their previous values.
REQ-014 An ALU result with alu_reg equal to 0 SHALL be dropped; a queue pop MAY proceed in that same cycle.
REQ-015 ld_ready SHALL be high exactly when fifo_count is less than FIFO_DEPTH.
- ld_ready SHALL be computed from registered state only.
- While the queue is full, ld_ready SHALL stay low even if a pop occurs in the same cycle.
REQ-016 An accepted load with ld_reg not equal to 0 SHALL be pushed at the tail.
REQ-017 An accepted load with ld_reg equal to 0 SHALL be consumed without being pushed.
REQ-018 When a push and a pop occur in the same cycle, fifo_count SHALL be unchanged and both operations SHALL take effect.
REQ-019 The queue SHALL be circular, with read and write pointers that wrap from FIFO_DEPTH-1 to 0; ordering SHALL be strictly FIFO.
REQ-020 The scoreboard SHALL be a 32-bit pending vector:
- iss_valid with iss_reg not equal to 0 SHALL set pending[iss_reg];
- a load write reaching the write port SHALL clear pending[wb reg] at that edge;
- if a set and a clear hit the same register in one cycle, the set SHALL win;
- pending[0] SHALL always be 0.
REQ-021 stall_1 SHALL equal pending[chk_addr_1] and stall_2 SHALL equal pending[chk_addr_2], both combinational from registered state.
REQ-022 An ALU write SHALL never modify the pending vector.

Reset
REQ-023 When rst_n is low at a rising edge, the block SHALL set wb_we=0, wb_write_reg=0, wb_write_data=0, fifo_count=0, both pointers to 0, and pending to all zeros.
REQ-024 During reset, ld_ready SHALL be 0, and any inputs presented in that cycle SHALL be discarded.
REQ-025 Queue contents SHALL be lost on reset taken mid-operation, and no stale write SHALL appear afterwards.
REQ-026 ld_ready SHALL first be 1 in the cycle after rst_n goes high.

Configuration
REQ-027 When macro WB_LOAD_BYPASS_EN is defined, an accepted load SHALL go directly to the write port in that cycle (1-cycle latency, queue untouched) if the queue is empty and no ALU write wins that cycle.
REQ-028 When WB_LOAD_BYPASS_EN is undefined, every accepted load SHALL pass through the queue, giving a minimum load-to-wb_we latency of 2 cycles.

Verification
REQ-029 Scenario: reset, then 3 cycles with rst_n high and all inputs idle -> wb_we=0, fifo_count=0, ld_ready=1, stall_1=stall_2=0.
REQ-030 Scenario: ALU writes r5=0x11111111 in the same cycle a load for r6=0xAAAA0000 is accepted -> wb_we cycle 1 shows r5, cycle 2 shows r6, and fifo_count goes 1 then 0.
REQ-031 Scenario: alu_valid held high with alu_reg not equal to 0 while 5 loads are offered, FIFO_DEPTH=4 -> 4 are accepted, ld_ready=0 while fifo_count=4, then the queue drains in order once alu_valid drops.
REQ-032 Scenario: iss_valid with r7, then chk_addr_1=7 -> stall_1=1; after the r7 load writes back, stall_1=0.
REQ-033 Scenario: set and clear of r7 in the same cycle -> stall_1 remains 1.
REQ-034 Scenario: a load to r0 and an ALU write to r0 -> no wb_we pulse, fifo_count stays 0, and stall for address 0 stays 0.
REQ-035 Scenario: reset asserted with fifo_count=3 -> no further wb_we pulses and fifo_count=0; with WB_LOAD_BYPASS_EN defined, a single idle load to r9 then produces wb_we after 1 cycle.
